// File: rtl/serial_adder_seq.sv
// Multi-cycle WIDTH-bit adder, BITS_PER_CYCLE bits per clock.
// Registered Sum/Carry/Overflow with start/busy/done handshake.
module serial_adder_seq #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad
      $error("BITS_PER_CYCLE must divide WIDTH, WIDTH >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_cy;
  logic             r_busy;
  logic             r_done;
  logic             r_carry;
  logic             r_ovf;

  logic [BPC:0]     w_chunk;
  logic             w_cmsb;
  logic             w_last;
  logic [WIDTH-1:0] w_part;

  // carry into the chunk MSB recovered as a ^ b ^ sum at that bit
  always_comb begin
    w_chunk = {1'b0, r_a[BPC-1:0]}
            + {1'b0, r_b[BPC-1:0]}
            + {{BPC{1'b0}}, r_cy};
    w_cmsb  = r_a[BPC-1] ^ r_b[BPC-1]
            ^ w_chunk[BPC-1];
    w_last  = (r_cnt == CW'(STEPS - 1));
    w_part  = r_part >> BPC;
    w_part[WIDTH-1 -: BPC] = w_chunk[BPC-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_cy    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_cy    <= Cin;
            r_cnt   <= '0;
            r_part  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a    <= r_a >> BPC;
          r_b    <= r_b >> BPC;
          r_cy   <= w_chunk[BPC];
          r_part <= w_part;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum   <= w_part;
            r_carry <= w_chunk[BPC];
            r_ovf   <= w_cmsb ^ w_chunk[BPC];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign Sum      = r_sum;
  assign Carry    = r_carry;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq: 8/1, 8/4 and exhaustive 4/2.
// Outputs sampled on the falling edge.
module tb_serial_adder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st0, st1, st2;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [3:0] a4, b4;
  logic       cin4;

  logic       bz0, dn0, c0, v0;
  logic [7:0] s0;
  logic       bz1, dn1, c1, v1;
  logic [7:0] s1;
  logic       bz2, dn2, c2, v2;
  logic [3:0] s2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0),
    .A(a8), .B(b8), .Cin(cin8),
    .busy(bz0), .done(dn0), .Sum(s0),
    .Carry(c0), .Overflow(v0)
  );

  serial_adder_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1),
    .A(a8), .B(b8), .Cin(cin8),
    .busy(bz1), .done(dn1), .Sum(s1),
    .Carry(c1), .Overflow(v1)
  );

  serial_adder_seq #(.WIDTH(4), .BITS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2),
    .A(a4), .B(b4), .Cin(cin4),
    .busy(bz2), .done(dn2), .Sum(s2),
    .Carry(c2), .Overflow(v2)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic rd(input int sel,
                    output logic [7:0] s,
                    output logic c, v, d, b);
    case (sel)
      0: begin s = s0; c = c0; v = v0; d = dn0; b = bz0; end
      1: begin s = s1; c = c1; v = v1; d = dn1; b = bz1; end
      default: begin
        s = {4'h0, s2}; c = c2; v = v2; d = dn2; b = bz2;
      end
    endcase
  endtask

  // drive one start in an IDLE cycle, wait for done, check, return in IDLE
  task automatic do_op(input int sel,
                       input logic [7:0] a, b,
                       input logic ci,
                       input logic [7:0] es,
                       input logic ec, ev,
                       input int lat,
                       input string nm);
    int n;
    logic [7:0] gs;
    logic gc, gv, gd, gb;
    case (sel)
      0: begin a8 = a; b8 = b; cin8 = ci; st0 = 1'b1; end
      1: begin a8 = a; b8 = b; cin8 = ci; st1 = 1'b1; end
      default: begin
        a4 = a[3:0]; b4 = b[3:0]; cin4 = ci; st2 = 1'b1;
      end
    endcase
    @(negedge clk);
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    n = 1;
    rd(sel, gs, gc, gv, gd, gb);
    while (!gd && n < 30) begin
      @(negedge clk);
      n++;
      rd(sel, gs, gc, gv, gd, gb);
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " result"}, {gs, gc, gv}, {es, ec, ev});
    chk({nm, " busy@done"}, gb, 1);
    @(negedge clk);
    rd(sel, gs, gc, gv, gd, gb);
    chk({nm, " idle"}, {gd, gb}, 2'b00);
  endtask

  initial begin
    int n, ndone, bad;
    logic [4:0] ref5;
    logic       rv;

    tv[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tv[1] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0};
    tv[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[5] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    tv[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    st0 = 1'b1; st1 = 1'b1; st2 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset u0", {bz0, dn0, s0, c0, v0}, 12'h0);
    chk("reset u1", {bz1, dn1, s1, c1, v1}, 12'h0);
    chk("reset u2", {bz2, dn2, s2, c2, v2}, 8'h0);
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      do_op(0, tv[i].a, tv[i].b, tv[i].cin,
            tv[i].s, tv[i].c, tv[i].v, 9,
            $sformatf("vec%0d", i));

    // start re-asserted mid-RUN must be ignored; Sum holds FF
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    n = 1; bad = 0;
    while (n < 9) begin
      if (n == 3) begin
        a8 = 8'h11; b8 = 8'h22; st0 = 1'b1;
      end
      if (n == 5) st0 = 1'b0;
      if (dn0 || !bz0 || s0 != 8'hFF) bad++;
      @(negedge clk);
      n++;
    end
    chk("hold during run", bad, 0);
    chk("hold done", {dn0, s0, c0, v0}, {1'b1, 8'h46, 2'b00});
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn0) ndone++;
    end
    chk("hold extra done", ndone, 0);
    chk("hold final sum", s0, 8'h46);

    // reset in the middle of RUN aborts with no done
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun busy", bz0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun cleared", {bz0, dn0, s0, c0, v0}, 12'h0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn0 || bz0) ndone++;
    end
    chk("midrun no done", ndone, 0);
    do_op(0, 8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0, 9,
          "after reset");

    do_op(1, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 3,
          "bpc4 A5+5A");
    do_op(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 3,
          "bpc4 7F+01");
    do_op(1, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 3,
          "bpc4 80+FF");

    for (int i = 0; i < 512; i++) begin
      logic [3:0] xa, xb;
      logic       xc;
      xa = i[8:5]; xb = i[4:1]; xc = i[0];
      ref5 = {1'b0, xa} + {1'b0, xb} + {4'h0, xc};
      rv = (xa[3] == xb[3]) && (ref5[3] != xa[3]);
      do_op(2, {4'h0, xa}, {4'h0, xb}, xc,
            {4'h0, ref5[3:0]}, ref5[4], rv, 3,
            $sformatf("w4 %h+%h+%0d", xa, xb, xc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
